alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Micro-sequencer that fetches 8-bit instruction words from the program ROM and drives the combinational ALU.
- Writes each ALU result back into a 4-entry register file.
- Sits between the ROM (upstream, 1-cycle registered read) and the ALU (downstream, combinational).
- Runs a program from address 0 until a HALT word or the end of the address space, then pulses done.

Parameters:
- BITS, 8, datapath / register width; matches the ALU BITS.
- ADDR_W, 4, ROM address width; matches the ROM SIZE. Program space is 2^ADDR_W words.
- OP, 4, ALU opcode width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  begin program run; sampled only in IDLE.
- busy  out  1  high from FETCH through DONE inclusive.
- done  out  1  one-cycle pulse when the run ends.
- err  out  1  sticky error flag; cleared on start and on reset.
- rom_en  out  1  ROM read enable.
- rom_addr  out  ADDR_W  ROM address (equals pc).
- rom_data  in  8  ROM read data; valid the cycle after rom_en is sampled.
- alu_en  out  1  drives the ALU's active-low reset input; 1 only in EXEC, else 0 (ALU outputs 0).
- alu_op  out  OP  ALU opcode.
- alu_a  out  BITS  ALU operand 1 = R[rd].
- alu_b  out  BITS  ALU operand 2 = R[rs].
- alu_result  in  BITS  ALU output.
- ld_en  in  1  register-file preload strobe; honoured only when busy=0.
- ld_addr  in  2  preload index.
- ld_data  in  BITS  preload value.
- rd_addr  in  2  readback index.
- rd_data  out  BITS  combinational R[rd_addr].

Behaviour:
- Reset (async, active-high): state=IDLE, pc=0, ir=0, R0..R3=0, busy=0, done=0, err=0, rom_en=0, alu_en=0, alu_op=0, alu_a=0, alu_b=0.
- Instruction format: [7:4] op, [3:2] rs, [1:0] rd.
  - Operation: R[rd] <= ALU(R[rd], R[rs], op).
  - op 0-7: ADD, SUB, MUL, DIV, MOD, XOR, NOR, XNOR.
  - op 0xF: HALT.
  - op 8-14: illegal.
- FSM states: IDLE, FETCH, DECODE, EXEC, DONE.
- IDLE:
  - start=1 -> FETCH, err<=0, pc<=0.
  - ld_en=1 writes R[ld_addr]<=ld_data.
  - start and ld_en in the same cycle: the load is performed and the run starts.
- FETCH: rom_en=1, rom_addr=pc -> DECODE.
- DECODE: ir<=rom_data; rom_en=0 -> EXEC.
- EXEC:
  - HALT: no write -> DONE.
  - Illegal op: err<=1, no write.
  - DIV/MOD with R[rs]==0: err<=1, no write.
  - Otherwise: R[rd]<=alu_result; results are truncated to BITS (SUB wraps modulo 2^BITS, MUL keeps the low BITS).
  - If pc==2^ADDR_W-1 -> DONE, pc<=0; else pc<=pc+1 -> FETCH.
  - alu_en=1, alu_op=ir[7:4], alu_a/alu_b driven from ir, all only in EXEC.
- DONE: done=1 for exactly one cycle -> IDLE.
- Latency: 3 cycles per instruction. A run of N instructions including HALT asserts done 3N clocks after the edge that samples start.
- Ignored events:
  - start while busy=1.
  - ld_en while busy=1 (register file unchanged).
- rom_en is never asserted outside FETCH.
- Reset mid-run: immediate return to IDLE; registers cleared; no done pulse.

Test Plan:
- Add: preload R0=5, R1=3; ROM[0]=0x04 (ADD rs=1 rd=0), ROM[1]=0xF0 -> done 6 clocks after start, R0=8, err=0, rom_en high exactly 2 cycles.
- Sub wrap and multiply truncation: R0=3, R1=5; ROM[0]=0x14 (SUB), ROM[1]=0x29 (MUL rs=2 rd=1) with R2=0x40, then HALT -> R0=0xFE, R1=0x40 (5*0x40 low byte), err=0.
- Divide by zero: R0=9, R2=0; ROM[0]=0x38 (DIV rs=2 rd=0), HALT -> err=1, R0=9; next start clears err.
- Illegal op: ROM[0]=0x90, HALT -> err=1, registers unchanged, done still pulses.
- No HALT: 16 XOR words -> done 48 clocks after start, pc=0, busy low afterwards.
- Reset mid-run (during second EXEC) and start/ld_en while busy -> all outputs and registers zero, no done; busy-time ld_en leaves registers unchanged.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// ROM fetch port and ALU operand/result port between the sequencer (master) and its neighbours (slave).
interface alu_sequencer_if #(
  parameter int BITS   = 8,
  parameter int ADDR_W = 4,
  parameter int OP     = 4
);
  logic              rom_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic              alu_en;
  logic [OP-1:0]     alu_op;
  logic [BITS-1:0]   alu_a;
  logic [BITS-1:0]   alu_b;
  logic [BITS-1:0]   alu_result;

  modport master (
    output rom_en, rom_addr, alu_en, alu_op, alu_a, alu_b,
    input  rom_data, alu_result
  );

  modport slave (
    input  rom_en, rom_addr, alu_en, alu_op, alu_a, alu_b,
    output rom_data, alu_result
  );
endinterface

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute sequencer over a 4-entry register file; 3 cycles per instruction.
// No backpressure: the ROM answers one cycle after rom_en and the ALU is combinational.
module alu_sequencer #(
  parameter int BITS   = 8,
  parameter int ADDR_W = 4,
  parameter int OP     = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic            err,
  input  logic            ld_en,
  input  logic [1:0]      ld_addr,
  input  logic [BITS-1:0] ld_data,
  input  logic [1:0]      rd_addr,
  output logic [BITS-1:0] rd_data,
  alu_sequencer_if.master bus
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_DONE} state_t;

  localparam logic [3:0]        OP_DIV  = 4'd3;
  localparam logic [3:0]        OP_MOD  = 4'd4;
  localparam logic [3:0]        OP_HALT = 4'hF;
  localparam logic [ADDR_W-1:0] LAST_PC = {ADDR_W{1'b1}};

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        ir;
  logic [BITS-1:0]   regs [4];

  logic [3:0] op_q;
  logic [1:0] rs_q;
  logic [1:0] rd_q;

  assign op_q         = ir[7:4];
  assign rs_q         = ir[3:2];
  assign rd_q         = ir[1:0];
  assign bus.rom_addr = pc;
  assign rd_data      = regs[rd_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      pc         <= '0;
      ir         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      bus.rom_en <= 1'b0;
      bus.alu_en <= 1'b0;
      bus.alu_op <= '0;
      bus.alu_a  <= '0;
      bus.alu_b  <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (ld_en) regs[ld_addr] <= ld_data;
          if (start) begin
            state      <= S_FETCH;
            err        <= 1'b0;
            pc         <= '0;
            busy       <= 1'b1;
            bus.rom_en <= 1'b1;
          end
        end
        S_FETCH: begin
          bus.rom_en <= 1'b0;
          state      <= S_DECODE;
        end
        S_DECODE: begin
          // Operands are taken straight from the ROM word so they are registered on entry to EXEC.
          ir         <= bus.rom_data;
          bus.alu_en <= 1'b1;
          bus.alu_op <= OP'(bus.rom_data[7:4]);
          bus.alu_a  <= regs[bus.rom_data[1:0]];
          bus.alu_b  <= regs[bus.rom_data[3:2]];
          state      <= S_EXEC;
        end
        S_EXEC: begin
          bus.alu_en <= 1'b0;
          bus.alu_op <= '0;
          bus.alu_a  <= '0;
          bus.alu_b  <= '0;
          if (op_q == OP_HALT) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            if (op_q[3]) begin
              err <= 1'b1;
            end else if ((op_q == OP_DIV || op_q == OP_MOD) && regs[rs_q] == '0) begin
              err <= 1'b1;
            end else begin
              regs[rd_q] <= bus.alu_result;
            end
            if (pc == LAST_PC) begin
              pc    <= '0;
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              pc         <= pc + ADDR_W'(1);
              state      <= S_FETCH;
              bus.rom_en <= 1'b1;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
